// File: rtl/lsu.sv
// Load/store unit: takes one execute-stage memory request at a time, runs a
// single word-wide transaction on the data-memory bus and returns load data
// extracted from the addressed byte lanes and sign- or zero-extended.
//
// Build option: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word requests skip the bus and complete the
//               next cycle with misalign=1 and rdata=0.
//   undefined - misalign is always 0; the offending low address bits are
//               ignored and the access proceeds on the bus.
//
// Ports:
//   clock, reset_n          clock (rising edge), async active-low reset
//   reqValid                one-cycle request pulse from execute
//   is_load, is_store       request kind (never both set)
//   size, is_unsigned       access size (0 byte, 1 half, 2/3 word), load extension
//   addr, wdata             effective byte address, right-aligned store data
//   respValid               one-cycle completion pulse
//   rdata, misalign         extended load data (held), misaligned flag
//   mem_req_valid/ready     bus request handshake
//   mem_we, mem_addr        bus write enable, word-aligned bus address
//   mem_wdata, mem_wstrb    lane-replicated store data, byte strobes
//   mem_resp_valid, mem_rdata  bus response pulse and read word
module lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  reqValid,
  output logic                  respValid,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  misalign,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [(DATA_W/8)-1:0] mem_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  // State and request fields captured at accept
  logic [1:0] state_q, state_d;
  logic       cap_load_q, cap_load_d;
  logic [1:0] cap_size_q, cap_size_d;
  logic       cap_unsigned_q, cap_unsigned_d;
  logic [1:0] cap_off_q, cap_off_d;

  // Next values of the registered outputs
  logic                  resp_d;
  logic [DATA_W-1:0]     rdata_d;
  logic                  misalign_d;
  logic                  req_valid_d;
  logic                  we_d;
  logic [ADDR_W-1:0]     addr_d;
  logic [DATA_W-1:0]     wdata_d;
  logic [STRB_W-1:0]     wstrb_d;

  logic                  accept_c;
  logic                  mem_op_c;
  logic                  trap_c;
  logic [DATA_W-1:0]     st_data_c;
  logic [STRB_W-1:0]     st_strb_c;
  logic [7:0]            ld_byte_c;
  logic [15:0]           ld_half_c;
  logic                  ld_sign_c;
  logic [DATA_W-1:0]     ld_ext_c;

  assign accept_c = reqValid && ((state_q == IDLE) || (state_q == DONE));
  assign mem_op_c = is_load || is_store;

`ifdef LSU_MISALIGN_TRAP_EN
  // Half needs addr[0]=0, word (size 2 or 3) needs addr[1:0]=0
  logic misaligned_c;
  assign misaligned_c = ((size == SZ_HALF) && addr[0]) ||
                        (size[1] && (addr[1:0] != 2'b00));
  assign trap_c = mem_op_c && misaligned_c;
`else
  assign trap_c = 1'b0;
`endif

  // Store lane replication and strobes from the incoming request
  always_comb begin
    st_data_c = wdata;
    st_strb_c = {STRB_W{1'b1}};
    case (size)
      SZ_BYTE: begin
        st_data_c = {(DATA_W/8){wdata[7:0]}};
        st_strb_c = STRB_W'(4'b0001) << addr[1:0];
      end
      SZ_HALF: begin
        st_data_c = {(DATA_W/16){wdata[15:0]}};
        st_strb_c = STRB_W'(4'b0011) << {addr[1], 1'b0};
      end
      default: begin
        st_data_c = wdata;
        st_strb_c = {STRB_W{1'b1}};
      end
    endcase
  end

  // Load lane extraction and extension using the captured request fields
  always_comb begin
    ld_byte_c = mem_rdata[7:0];
    case (cap_off_q)
      2'd0:    ld_byte_c = mem_rdata[7:0];
      2'd1:    ld_byte_c = mem_rdata[15:8];
      2'd2:    ld_byte_c = mem_rdata[23:16];
      default: ld_byte_c = mem_rdata[31:24];
    endcase
    ld_half_c = cap_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_sign_c = 1'b0;
    ld_ext_c  = mem_rdata;
    case (cap_size_q)
      SZ_BYTE: begin
        ld_sign_c = ~cap_unsigned_q & ld_byte_c[7];
        ld_ext_c  = {{(DATA_W-8){ld_sign_c}}, ld_byte_c};
      end
      SZ_HALF: begin
        ld_sign_c = ~cap_unsigned_q & ld_half_c[15];
        ld_ext_c  = {{(DATA_W-16){ld_sign_c}}, ld_half_c};
      end
      default: begin
        ld_sign_c = 1'b0;
        ld_ext_c  = mem_rdata;
      end
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    cap_load_d     = cap_load_q;
    cap_size_d     = cap_size_q;
    cap_unsigned_d = cap_unsigned_q;
    cap_off_d      = cap_off_q;
    resp_d         = 1'b0;
    rdata_d        = rdata;
    misalign_d     = misalign;
    req_valid_d    = mem_req_valid;
    we_d           = mem_we;
    addr_d         = mem_addr;
    wdata_d        = mem_wdata;
    wstrb_d        = mem_wstrb;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept_c) begin
          cap_load_d     = is_load;
          cap_size_d     = size;
          cap_unsigned_d = is_unsigned;
          cap_off_d      = addr[1:0];
          if (mem_op_c && !trap_c) begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            we_d        = is_store;
            addr_d      = {addr[ADDR_W-1:2], 2'b00};
            wdata_d     = is_store ? st_data_c : '0;
            wstrb_d     = is_store ? st_strb_c : '0;
          end else begin
            // Non-memory or trapped request: complete without the bus
            state_d    = DONE;
            resp_d     = 1'b1;
            rdata_d    = '0;
            misalign_d = trap_c;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d     = WAIT;
          req_valid_d = 1'b0;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d    = DONE;
          resp_d     = 1'b1;
          rdata_d    = cap_load_q ? ld_ext_c : '0;
          misalign_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, capture and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cap_load_q     <= 1'b0;
      cap_size_q     <= 2'd0;
      cap_unsigned_q <= 1'b0;
      cap_off_q      <= 2'd0;
      respValid      <= 1'b0;
      rdata          <= '0;
      misalign       <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
    end else begin
      state_q        <= state_d;
      cap_load_q     <= cap_load_d;
      cap_size_q     <= cap_size_d;
      cap_unsigned_q <= cap_unsigned_d;
      cap_off_q      <= cap_off_d;
      respValid      <= resp_d;
      rdata          <= rdata_d;
      misalign       <= misalign_d;
      mem_req_valid  <= req_valid_d;
      mem_we         <= we_d;
      mem_addr       <= addr_d;
      mem_wdata      <= wdata_d;
      mem_wstrb      <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: expected completions are queued when a
// request is issued and compared when respValid pulses.
module tb_lsu;

  logic        clock;
  logic        reset_n;
  logic        reqValid;
  logic        respValid;
  logic        is_load;
  logic        is_store;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        misalign;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  lsu dut (
    .clock(clock), .reset_n(reset_n), .reqValid(reqValid), .respValid(respValid),
    .is_load(is_load), .is_store(is_store), .size(size), .is_unsigned(is_unsigned),
    .addr(addr), .wdata(wdata), .rdata(rdata), .misalign(misalign),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp_e;
  int          vecs = 0;
  int          errs = 0;
  int          cyc = 0;
  int          t_issue = 0;
  int          last_resp_cyc = 0;
  int          resp_count = 0;
  bit          req_seen = 0;
  logic        obs_we;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_wstrb;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: every completion must match the oldest queued expectation
  always @(negedge clock) begin
    if (reset_n && mem_req_valid) req_seen = 1;
    if (reset_n && respValid) begin
      resp_count    = resp_count + 1;
      last_resp_cyc = cyc;
      vecs++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_resp: respValid=1 rdata=%h, required no response", rdata);
        errs++;
      end else begin
        exp_e = exp_q.pop_front();
        if (rdata !== exp_e.rdata || misalign !== exp_e.mis) begin
          $display("FAIL resp: rdata=%h misalign=%b, required rdata=%h misalign=%b",
                   rdata, misalign, exp_e.rdata, exp_e.mis);
          errs++;
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] rd, input logic mis);
    exp_t e;
    e.rdata = rd;
    e.mis   = mis;
    exp_q.push_back(e);
  endtask

  // Drive a one-cycle request pulse starting at the current (negedge) time
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    is_load     = ld;
    is_store    = st;
    size        = sz;
    is_unsigned = uns;
    addr        = a;
    wdata       = wd;
    t_issue     = cyc;
    reqValid    = 1'b1;
    @(negedge clock);
    reqValid    = 1'b0;
  endtask

  // Act as the memory: optional stall with stability checks, then handshake and respond
  task automatic serve(input int stall, input logic [31:0] rd, input bit pulse_req);
    for (int i = 0; i < 20 && !mem_req_valid; i++) @(negedge clock);
    vecs++;
    if (!mem_req_valid) begin
      $display("FAIL serve_timeout: mem_req_valid=%b, required 1", mem_req_valid);
      errs++;
    end else begin
      obs_we    = mem_we;
      obs_addr  = mem_addr;
      obs_wdata = mem_wdata;
      obs_wstrb = mem_wstrb;
      for (int i = 0; i < stall; i++) begin
        if (pulse_req && i == 1) begin
          is_load = 1'b1; is_store = 1'b0; size = 2'd0; is_unsigned = 1'b1;
          addr = 32'h0000_0003; reqValid = 1'b1;
        end
        @(negedge clock);
        reqValid = 1'b0;
        vecs++;
        if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb} !==
            {1'b1, obs_we, obs_addr, obs_wdata, obs_wstrb}) begin
          $display("FAIL stall_stable: valid=%b we=%b addr=%h wdata=%h strb=%b, required 1 %b %h %h %b",
                   mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
                   obs_we, obs_addr, obs_wdata, obs_wstrb);
          errs++;
        end
      end
      mem_req_ready = 1'b1;
      @(negedge clock);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = rd;
      @(negedge clock);
      mem_resp_valid = 1'b0;
    end
  endtask

  // Wait (bounded) until the scoreboard has drained
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL %s_timeout: %0d responses outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_bus(input string nm, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] st);
    vecs++;
    if ({obs_we, obs_addr, obs_wdata, obs_wstrb} !== {we, a, wd, st}) begin
      $display("FAIL %s_bus: we=%b addr=%h wdata=%h strb=%b, required we=%b addr=%h wdata=%h strb=%b",
               nm, obs_we, obs_addr, obs_wdata, obs_wstrb, we, a, wd, st);
      errs++;
    end
  endtask

  task automatic check_lat(input string nm, input int lat);
    vecs++;
    if (last_resp_cyc - t_issue !== lat) begin
      $display("FAIL %s_latency: got %0d cycles, required %0d", nm, last_resp_cyc - t_issue, lat);
      errs++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    vecs++;
    if ({respValid, misalign, mem_req_valid, mem_we, rdata, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      $display("FAIL reset_outputs: resp=%b mis=%b rv=%b we=%b rdata=%h addr=%h wdata=%h strb=%b, required all 0",
               respValid, misalign, mem_req_valid, mem_we, rdata, mem_addr, mem_wdata, mem_wstrb);
      errs++;
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_word_store();
    push_exp(32'h0, 1'b0);
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    serve(0, 32'h0, 1'b0);
    wait_done("word_store");
    check_bus("word_store", 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
    check_lat("word_store", 3);
  endtask

  task automatic test_byte_load();
    push_exp(32'hFFFF_FF80, 1'b0);
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0);
    serve(0, 32'h8012_3456, 1'b0);
    wait_done("byte_load_s");
    check_bus("byte_load_s", 1'b0, 32'h0000_0200, 32'h0, 4'b0000);
    push_exp(32'h0000_0080, 1'b0);
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0);
    serve(0, 32'h8012_3456, 1'b0);
    wait_done("byte_load_u");
  endtask

  task automatic test_stores_lanes();
    push_exp(32'h0, 1'b0);
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h0000_ABCD);
    serve(0, 32'h0, 1'b0);
    wait_done("half_store");
    check_bus("half_store", 1'b1, 32'h0000_0010, 32'hABCD_ABCD, 4'b1100);
    push_exp(32'h0, 1'b0);
    issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0101, 32'h1234_565A);
    serve(0, 32'h0, 1'b0);
    wait_done("byte_store");
    check_bus("byte_store", 1'b1, 32'h0000_0100, 32'h5A5A_5A5A, 4'b0010);
  endtask

  task automatic test_stall();
    int rc0;
    rc0 = resp_count;
    push_exp(32'h1122_3344, 1'b0);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0);
    serve(5, 32'h1122_3344, 1'b1);
    wait_done("stall");
    repeat (4) @(negedge clock);
    vecs++;
    if (resp_count - rc0 !== 1) begin
      $display("FAIL stall_resp_count: got %0d responses, required 1", resp_count - rc0);
      errs++;
    end
  endtask

  task automatic test_reset_mid();
    int rc0;
    rc0 = resp_count;
    // Reset while stalled in REQ: request must drop at once
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    vecs++;
    if (mem_req_valid !== 1'b0 || mem_addr !== 32'h0) begin
      $display("FAIL reset_req: mem_req_valid=%b mem_addr=%h, required 0 0", mem_req_valid, mem_addr);
      errs++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    // Reset while in WAIT, then a stray response
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0304, 32'hCAFE_0001);
    mem_req_ready = 1'b1;
    @(negedge clock);
    mem_req_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    vecs++;
    if ({respValid, misalign, mem_req_valid, mem_we, rdata, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      $display("FAIL reset_wait: resp=%b mis=%b rv=%b we=%b rdata=%h addr=%h wdata=%h strb=%b, required all 0",
               respValid, misalign, mem_req_valid, mem_we, rdata, mem_addr, mem_wdata, mem_wstrb);
      errs++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h5555_AAAA;
    @(negedge clock);
    mem_resp_valid = 1'b0;
    repeat (3) @(negedge clock);
    vecs++;
    if (resp_count !== rc0 || dut.state_q !== 2'd0) begin
      $display("FAIL reset_stray: responses=%0d state=%0d, required 0 responses state 0",
               resp_count - rc0, dut.state_q);
      errs++;
    end
  endtask

  task automatic test_back_to_back();
    // Half signed load, then a byte load and a non-memory op accepted in DONE
    push_exp(32'hFFFF_8001, 1'b0);
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0);
    serve(0, 32'h8001_1234, 1'b0);
    vecs++;
    if (respValid !== 1'b1 || cyc - t_issue !== 3) begin
      $display("FAIL b2b_first: respValid=%b at cycle %0d, required 1 at cycle 3", respValid, cyc - t_issue);
      errs++;
    end
    push_exp(32'h0000_00AB, 1'b0);
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0001, 32'h0);
    serve(0, 32'h0000_AB00, 1'b0);
    wait_done("b2b_second");
    check_lat("b2b_second", 3);
    push_exp(32'h0, 1'b0);
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0);
    wait_done("nonmem");
    check_lat("nonmem", 1);
  endtask

  task automatic test_misalign();
    req_seen = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    push_exp(32'h0, 1'b1);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0);
    wait_done("mis_word");
    check_lat("mis_word", 1);
    vecs++;
    if (req_seen !== 1'b0) begin
      $display("FAIL mis_word_bus: mem_req_valid seen=%b, required 0", req_seen);
      errs++;
    end
    push_exp(32'h0, 1'b1);
    issue(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0003, 32'h0);
    wait_done("mis_half");
`else
    push_exp(32'hCAFE_F00D, 1'b0);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0);
    serve(0, 32'hCAFE_F00D, 1'b0);
    wait_done("mis_word");
    check_bus("mis_word", 1'b0, 32'h0000_0100, 32'h0, 4'b0000);
    push_exp(32'h0000_BEEF, 1'b0);
    issue(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0003, 32'h0);
    serve(0, 32'hBEEF_1234, 1'b0);
    wait_done("mis_half");
`endif
  endtask

  initial begin
    reset_n        = 1'b0;
    reqValid       = 1'b0;
    is_load        = 1'b0;
    is_store       = 1'b0;
    size           = 2'd0;
    is_unsigned    = 1'b0;
    addr           = 32'h0;
    wdata          = 32'h0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
    test_reset();
    test_word_store();
    test_byte_load();
    test_stores_lanes();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_misalign();
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
